// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - ID-stage scoreboard for in-flight multi-cycle register writes
//
// Tracks a remaining-latency counter per architectural register (x0 excluded).
// Issue is stalled when a source is still too far from completion to be
// forwarded, or when a new write would complete before an older one to the
// same destination.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   flush            synchronous clear of all pending state
//   issue_valid      instruction in ID requests issue
//   issue_regwrite   instruction writes issue_rd
//   issue_rd/rs1/rs2 destination and source register indices
//   issue_lat        result latency in cycles (0 treated as 1, clamped to MAX_LAT)
//   stall            combinational hold of ID/IF
//   issue_accept     issue_valid & !stall & !flush
//   pending_mask     bit r set while register r has an in-flight write
//   retire_mask      bit r pulses the cycle after its counter decrements 1->0
//   busy             any register pending
module reg_scoreboard #(
    parameter int NREG      = 32,
    parameter int MAX_LAT   = 7,
    parameter int FWD_SLACK = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            issue_valid,
    input  logic            issue_regwrite,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [2:0]      issue_lat,
    output logic            stall,
    output logic            issue_accept,
    output logic [NREG-1:0] pending_mask,
    output logic [NREG-1:0] retire_mask,
    output logic            busy
);

    localparam int CW = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] SLACK = CW'(FWD_SLACK);

    logic [CW-1:0] cnt [NREG];
    logic [CW-1:0] lat_eff;
    logic [CW-1:0] cnt_rs1;
    logic [CW-1:0] cnt_rs2;
    logic [CW-1:0] cnt_rd;
    logic          raw_rs1;
    logic          raw_rs2;
    logic          waw;
    logic          load_en;

    // Zero latency is treated as single-cycle; anything longer than the
    // counter can represent saturates at MAX_LAT.
    always_comb begin
        lat_eff = CW'(MAX_LAT);
        if (issue_lat == 3'd0) begin
            lat_eff = CW'(1);
        end else if (32'(issue_lat) <= MAX_LAT) begin
            lat_eff = CW'(issue_lat);
        end
    end

    always_comb begin
        cnt_rs1 = cnt[issue_rs1];
        cnt_rs2 = cnt[issue_rs2];
        cnt_rd  = cnt[issue_rd];
    end

    assign raw_rs1 = (issue_rs1 != 5'd0) && (cnt_rs1 > SLACK);
    assign raw_rs2 = (issue_rs2 != 5'd0) && (cnt_rs2 > SLACK);
    // An older write still needing >= lat_eff cycles would land on top of
    // (or after) the younger result and leave a stale value in the file.
    assign waw     = issue_regwrite && (issue_rd != 5'd0) && (cnt_rd >= lat_eff);

    assign stall        = issue_valid && (raw_rs1 || raw_rs2 || waw);
    assign issue_accept = issue_valid && !stall && !flush;
    assign load_en      = issue_accept && issue_regwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            retire_mask <= '0;
        end else begin
            retire_mask <= '0;
            cnt[0]      <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else if (load_en && (issue_rd == 5'(r))) begin
                    // A reload wins over the decrement, so no retire pulse.
                    cnt[r] <= lat_eff;
                end else if (cnt[r] != '0) begin
                    cnt[r]         <= cnt[r] - CW'(1);
                    retire_mask[r] <= (cnt[r] == CW'(1));
                end
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            pending_mask[r] = (cnt[r] != '0);
        end
    end

    assign busy = |pending_mask;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard-checked directed bench for reg_scoreboard
module tb_reg_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic        issue_regwrite;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [2:0]  issue_lat;
    logic        stall;
    logic        issue_accept;
    logic [31:0] pending_mask;
    logic [31:0] retire_mask;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        stall;
        logic        acc;
        logic [31:0] pend;
        logic [31:0] ret;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    reg_scoreboard #(.NREG(32), .MAX_LAT(7), .FWD_SLACK(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_rd       (issue_rd),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_lat      (issue_lat),
        .stall          (stall),
        .issue_accept   (issue_accept),
        .pending_mask   (pending_mask),
        .retire_mask    (retire_mask),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; one expectation per checked cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".stall"},  32'(stall),        32'(e.stall));
            chk({e.name, ".accept"}, 32'(issue_accept), 32'(e.acc));
            chk({e.name, ".pending"}, pending_mask,     e.pend);
            chk({e.name, ".retire"},  retire_mask,      e.ret);
            chk({e.name, ".busy"},   32'(busy),         32'(e.busy));
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected during that cycle.
    task automatic step(input string nm, input logic rst, input logic fl,
                        input logic v, input logic rw, input int rd, input int rs1,
                        input int rs2, input int lat,
                        input logic e_stall, input logic e_acc,
                        input logic [31:0] e_pend, input logic [31:0] e_ret);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rst;
        flush          = fl;
        issue_valid    = v;
        issue_regwrite = rw;
        issue_rd       = 5'(rd);
        issue_rs1      = 5'(rs1);
        issue_rs2      = 5'(rs2);
        issue_lat      = 3'(lat);
        e.name  = nm;
        e.stall = e_stall;
        e.acc   = e_acc;
        e.pend  = e_pend;
        e.ret   = e_ret;
        e.busy  = (e_pend != 32'd0);
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_regwrite = 1'b0;
        issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0; issue_lat = '0;

        //    name         rst fl v rw rd rs1 rs2 lat  stall acc pend          retire
        step("reset0",     0, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h0);
        step("reset1",     0, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h0);
        // RAW: rd=5 lat=3, consumer stalls while cnt > 1
        step("raw_iss",    1, 0, 1, 1, 5, 0,  0,  3,   0, 1, 32'h0,        32'h0);
        step("raw_c3",     1, 0, 1, 0, 0, 5,  0,  1,   1, 0, 32'h20,       32'h0);
        step("raw_c2",     1, 0, 1, 0, 0, 5,  0,  1,   1, 0, 32'h20,       32'h0);
        step("raw_c1",     1, 0, 1, 0, 0, 5,  0,  1,   0, 1, 32'h20,       32'h0);
        step("raw_ret",    1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h20);
        // lat=1 producer is immediately forwardable
        step("l1_iss",     1, 0, 1, 1, 4, 0,  0,  1,   0, 1, 32'h0,        32'h0);
        step("l1_use",     1, 0, 1, 0, 0, 0,  4,  1,   0, 1, 32'h10,       32'h0);
        step("l1_ret",     1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h10);
        // WAW: rd=6 lat=5 pending, younger rd=6 lat=2 waits until cnt < 2
        step("waw_iss",    1, 0, 1, 1, 6, 0,  0,  5,   0, 1, 32'h0,        32'h0);
        step("waw_idle",   1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h40,       32'h0);
        step("waw_c4",     1, 0, 1, 1, 6, 0,  0,  2,   1, 0, 32'h40,       32'h0);
        step("waw_c3",     1, 0, 1, 1, 6, 0,  0,  2,   1, 0, 32'h40,       32'h0);
        step("waw_c2",     1, 0, 1, 1, 6, 0,  0,  2,   1, 0, 32'h40,       32'h0);
        step("waw_c1",     1, 0, 1, 1, 6, 0,  0,  2,   0, 1, 32'h40,       32'h0);
        step("waw_rl2",    1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h40,       32'h0);
        step("waw_rl1",    1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h40,       32'h0);
        step("waw_ret",    1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h40);
        // x0 is never tracked
        step("x0_iss",     1, 0, 1, 1, 0, 0,  0,  7,   0, 1, 32'h0,        32'h0);
        step("x0_use",     1, 0, 1, 1, 0, 0,  0,  7,   0, 1, 32'h0,        32'h0);
        // flush clears pending state without retire pulses
        step("fl_iss3",    1, 0, 1, 1, 3, 0,  0,  4,   0, 1, 32'h0,        32'h0);
        step("fl_iss7",    1, 0, 1, 1, 7, 0,  0,  6,   0, 1, 32'h8,        32'h0);
        step("fl_go",      1, 1, 1, 1, 9, 0,  0,  2,   0, 0, 32'h88,       32'h0);
        step("fl_after",   1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h0);
        step("fl_after2",  1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h0);
        // flush does not gate stall
        step("fl_st_iss",  1, 0, 1, 1, 3, 0,  0,  4,   0, 1, 32'h0,        32'h0);
        step("fl_st",      1, 1, 1, 0, 0, 3,  0,  1,   1, 0, 32'h8,        32'h0);
        step("fl_st_aft",  1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h0);
        // latency clamp: 0 -> 1, 7 -> 7
        step("clamp0",     1, 0, 1, 1, 10, 0, 0,  0,   0, 1, 32'h0,        32'h0);
        step("clamp7",     1, 0, 1, 1, 11, 10, 0, 7,   0, 1, 32'h400,      32'h0);
        step("c7_raw",     1, 0, 1, 0, 0, 11, 0,  1,   1, 0, 32'h800,      32'h400);
        step("c7_waw_ok",  1, 0, 1, 1, 11, 0, 0,  7,   0, 1, 32'h800,      32'h0);
        step("c7_waw_st",  1, 0, 1, 1, 11, 0, 0,  7,   1, 0, 32'h800,      32'h0);
        // async reset mid-count clears everything at once
        step("rst_mid",    0, 0, 1, 0, 0, 11, 0,  1,   0, 1, 32'h0,        32'h0);
        step("rst_rel",    1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h0);
        step("rst_post",   1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 32'h0,        32'h0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
